// File: rtl/wm_start_ctrl_if.sv
// Signal bundle between the washing-machine front panel, the start controller
// and the downstream wash/rinse/spin sequencer.
interface wm_start_ctrl_if;
  logic start_btn;
  logic door_closed;
  logic spin;
  logic start;
  logic door_lock;
  logic busy;
  logic fault;

  modport master (
    input  start_btn,
    input  door_closed,
    input  spin,
    output start,
    output door_lock,
    output busy,
    output fault
  );

  modport slave (
    output start_btn,
    output door_closed,
    output spin,
    input  start,
    input  door_lock,
    input  busy,
    input  fault
  );
endinterface

// File: rtl/wm_start_ctrl.sv
// Start controller: debounces the start button, interlocks and locks the door,
// fires a one-cycle start to the sequencer and holds the lock until spin-down.
module wm_start_ctrl #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned LOCK_CYCLES   = 3,
  parameter int unsigned RUN_TIMEOUT   = 8,
  parameter int unsigned UNLOCK_CYCLES = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  wm_start_ctrl_if.master bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DEBOUNCE = 3'd1;
  localparam logic [2:0] LOCK     = 3'd2;
  localparam logic [2:0] FIRE     = 3'd3;
  localparam logic [2:0] RUN      = 3'd4;
  localparam logic [2:0] UNLOCK   = 3'd5;
  localparam logic [2:0] FAULT    = 3'd6;

  localparam logic [7:0] DB_LAST     = 8'(DB_CYCLES - 1);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CYCLES - 1);
  localparam logic [7:0] RUN_LAST    = 8'(RUN_TIMEOUT - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       btn_s_q, btn_s_d;
  logic       btn_q, btn_d;
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  logic       rise;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       start_q, start_d;
  logic       lock_q, lock_d;
  logic       busy_q, busy_d;
  logic       fault_q, fault_d;

  // The synchroniser contents are meaningless for two cycles after reset; a
  // button still held across reset must be seen released before it can arm.
  always_comb begin
    sync1_d  = bus.start_btn;
    btn_s_d  = sync1_q;
    btn_d    = btn_s_q;
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & ~btn_s_q);
    rise     = btn_s_q & ~btn_q & armed_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise && bus.door_closed) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!btn_s_q || !bus.door_closed) state_d = IDLE;
        else if (cnt_q == DB_LAST)        state_d = LOCK;
      end
      LOCK: begin
        if (!bus.door_closed)         state_d = FAULT;
        else if (cnt_q == LOCK_LAST)  state_d = FIRE;
      end
      FIRE: begin
        state_d = RUN;
      end
      RUN: begin
        // Door is locked here, so a simultaneous drop is treated as a glitch.
        if (bus.spin)                                  state_d = UNLOCK;
        else if (!bus.door_closed || cnt_q == RUN_LAST) state_d = FAULT;
      end
      UNLOCK: begin
        if (cnt_q == UNLOCK_LAST) state_d = IDLE;
      end
      FAULT: begin
        if (bus.door_closed && !btn_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Timed states exit at PARAM-1; IDLE and FAULT simply saturate.
  always_comb begin
    if (state_d != state_q)   cnt_d = 8'd0;
    else if (cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
    else                      cnt_d = cnt_q;
  end

  // Outputs are registered from the next state so they change cleanly with state.
  always_comb begin
    start_d = (state_d == FIRE);
    lock_d  = (state_d == LOCK) || (state_d == FIRE) ||
              (state_d == RUN)  || (state_d == UNLOCK);
    busy_d  = lock_d || (state_d == DEBOUNCE);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      btn_s_q  <= 1'b0;
      btn_q    <= 1'b0;
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      start_q  <= 1'b0;
      lock_q   <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      btn_s_q  <= btn_s_d;
      btn_q    <= btn_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      lock_q   <= lock_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.start     = start_q;
  assign bus.door_lock = lock_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_wm_start_ctrl.sv
// Scenario-table bench for wm_start_ctrl: per-scenario timing tallies plus a
// start-pulse scoreboard, and a hand-written asynchronous reset sequence.
module tb_wm_start_ctrl;

  logic clk;
  logic reset_n;

  wm_start_ctrl_if bus_if ();

  wm_start_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    b1_on;
    int    b1_len;
    int    b2_on;
    int    b2_len;
    int    d_lo;
    int    d_hi;
    bit    spin_en;
    int    exp_start;
    int    exp_lock;
    int    exp_busy;
    int    exp_fault;
    int    exp_fault_first;
  } vec_t;

  vec_t vecs [7];

  int n_cmp = 0;
  int n_bad = 0;
  int sb [$];
  int cur;
  int spin_at;
  bit seq_en;
  int lock_n, busy_n, fault_n, fault_first;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic clear_tallies();
    lock_n = 0;
    busy_n = 0;
    fault_n = 0;
    fault_first = -1;
  endtask

  // One clock: drive inputs, wait for the edge, sample and score.
  task automatic cycle(input logic btn, input logic door);
    bus_if.start_btn   = btn;
    bus_if.door_closed = door;
    bus_if.spin        = seq_en && (cur == spin_at);
    @(posedge clk);
    #1;
    cur++;
    if (bus_if.start) begin
      spin_at = cur + 3;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_start: got start at cycle %0d, required none", cur);
      end else begin
        chk("start_cycle", cur, sb.pop_front());
      end
    end
    if (bus_if.door_lock) lock_n++;
    if (bus_if.busy)      busy_n++;
    if (bus_if.fault) begin
      fault_n++;
      if (fault_first < 0) fault_first = cur;
    end
  endtask

  task automatic idle(input int n);
    seq_en  = 1'b0;
    spin_at = -1;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
  endtask

  task automatic run_scenario(input vec_t v);
    logic btn, door;
    cur     = 0;
    spin_at = -1;
    seq_en  = v.spin_en;
    clear_tallies();
    if (v.exp_start >= 0) sb.push_back(v.exp_start);
    for (int t = 0; t < 40; t++) begin
      btn  = ((t >= v.b1_on) && (t < v.b1_on + v.b1_len)) ||
             ((t >= v.b2_on) && (t < v.b2_on + v.b2_len));
      door = !((t >= v.d_lo) && (t < v.d_hi));
      cycle(btn, door);
    end
    chk({v.name, "/pending_start"}, sb.size(), 0);
    sb.delete();
    chk({v.name, "/lock_cycles"}, lock_n, v.exp_lock);
    chk({v.name, "/busy_cycles"}, busy_n, v.exp_busy);
    chk({v.name, "/fault_cycles"}, fault_n, v.exp_fault);
    chk({v.name, "/fault_first"}, fault_first, v.exp_fault_first);
    chk({v.name, "/end_busy"}, int'(bus_if.busy), 0);
    chk({v.name, "/end_fault"}, int'(bus_if.fault), 0);
    $display("scenario %-10s lock=%0d busy=%0d fault=%0d first_fault=%0d",
             v.name, lock_n, busy_n, fault_n, fault_first);
    idle(4);
  endtask

  initial begin
    // name, b1_on, b1_len, b2_on, b2_len, d_lo, d_hi, spin, start, lock, busy, fault, fault_first
    vecs[0] = '{"nominal",  0, 20, 0,  0,  0,  0, 1'b1, 10, 12, 16,  0, -1};
    vecs[1] = '{"bounce",   0,  2, 3, 10,  0,  0, 1'b1, 13, 12, 18,  0, -1};
    vecs[2] = '{"door_lock",0, 20, 0,  0,  8, 14, 1'b1, -1,  2,  6, 14,  9};
    vecs[3] = '{"timeout",  0, 20, 0,  0,  0,  0, 1'b0, 10, 12, 16,  4, 19};
    vecs[4] = '{"priority", 0, 20, 0,  0, 13, 16, 1'b1, 10, 12, 16,  0, -1};
    vecs[5] = '{"fire_drop",0, 20, 0,  0, 10, 12, 1'b1, 10,  5,  9, 11, 12};
    vecs[6] = '{"door_open",0, 20, 0,  0,  0,  6, 1'b1, -1,  0,  0,  0, -1};

    reset_n            = 1'b0;
    bus_if.start_btn   = 1'b0;
    bus_if.door_closed = 1'b1;
    bus_if.spin        = 1'b0;
    cur     = 0;
    spin_at = -1;
    seq_en  = 1'b0;
    clear_tallies();

    repeat (3) @(posedge clk);
    #1;
    chk("reset/start", int'(bus_if.start), 0);
    chk("reset/door_lock", int'(bus_if.door_lock), 0);
    chk("reset/busy", int'(bus_if.busy), 0);
    chk("reset/fault", int'(bus_if.fault), 0);
    reset_n = 1'b1;
    idle(6);

    for (int i = 0; i < 7; i++) run_scenario(vecs[i]);

    // Asynchronous reset in RUN cycle 2 with the button still held.
    cur     = 0;
    spin_at = -1;
    seq_en  = 1'b1;
    clear_tallies();
    sb.push_back(10);
    for (int t = 0; t < 12; t++) cycle(1'b1, 1'b1);
    chk("rst_mid/busy_before", int'(bus_if.busy), 1);
    chk("rst_mid/lock_before", int'(bus_if.door_lock), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid/start", int'(bus_if.start), 0);
    chk("rst_mid/door_lock", int'(bus_if.door_lock), 0);
    chk("rst_mid/busy", int'(bus_if.busy), 0);
    chk("rst_mid/fault", int'(bus_if.fault), 0);
    chk("rst_mid/pending_start", sb.size(), 0);
    sb.delete();
    spin_at = -1;
    seq_en  = 1'b0;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    reset_n = 1'b1;
    clear_tallies();
    for (int t = 0; t < 30; t++) cycle(1'b1, 1'b1);
    chk("rst_held/lock_cycles", lock_n, 0);
    chk("rst_held/busy_cycles", busy_n, 0);
    chk("rst_held/fault_cycles", fault_n, 0);
    $display("reset mid-run: held button after release gave lock=%0d busy=%0d", lock_n, busy_n);
    idle(6);
    run_scenario(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wm_start_ctrl.md
# wm_start_ctrl

Front-end controller that sits directly upstream of the wash/rinse/spin sequencer. It synchronises and debounces the raw start button, checks the door interlock, engages the door lock, and issues a single-cycle `start` pulse to the sequencer. It then holds the lock until the sequencer's `spin` phase is seen and a spin-down delay expires. It also flags door-open and sequencer-timeout faults.

## Interface
- `DB_CYCLES`, default 4: number of consecutive cycles the synchronised button and `door_closed` must stay high. Legal range 1..255.
- `LOCK_CYCLES`, default 3: lock-settle time, in cycles, before `start` is issued. Legal range 1..255.
- `RUN_TIMEOUT`, default 8: maximum number of RUN cycles to wait for `spin`. Legal range 1..255.
- `UNLOCK_CYCLES`, default 5: spin-down hold time, in cycles, after `spin`. Legal range 1..255.
- `clk`  in  1  the single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  raw push button, asynchronous to `clk`.
- `door_closed`  in  1  door switch, synchronous to `clk`; 1 means closed.
- `spin`  in  1  spin-phase indication from the downstream sequencer.
- `start`  out  1  one-cycle request to the sequencer.
- `door_lock`  out  1  door lock solenoid drive.
- `busy`  out  1  a cycle is in progress.
- `fault`  out  1  latched fault indication.

## Operation
- **Button conditioning:** `start_btn` passes through a 2-flop synchroniser to give `btn_s`. A third flop gives `btn_q`. The rise event is `btn_s & ~btn_q`.
- **Counter:** one 8-bit counter `cnt`. It clears on every state change. It never wraps, because every exit compares against `PARAM-1`.
- **State register:** an asynchronous `reset_n` low forces state IDLE. The same reset clears `cnt`, all synchroniser/edge flops and every output to 0, including a reset mid-cycle. The lock is released immediately on reset.
- **IDLE**
  - Outputs: all 0.
  - Goes to DEBOUNCE on a rise event with `door_closed`=1.
  - A rise event while the door is open is ignored.
  - A button that is held through the cycle never re-triggers; an edge is required.
- **DEBOUNCE**
  - Outputs: all 0 except `busy`=1.
  - Goes to IDLE if `btn_s`=0 or `door_closed`=0.
  - Goes to LOCK when `cnt`==`DB_CYCLES-1` and both inputs are still high.
  - Residency: exactly `DB_CYCLES` cycles.
- **LOCK**
  - Outputs: `door_lock`=1, `busy`=1.
  - Goes to FAULT if `door_closed`=0.
  - Goes to FIRE when `cnt`==`LOCK_CYCLES-1`.
- **FIRE**
  - Outputs: `start`=1, `door_lock`=1, `busy`=1.
  - Lasts exactly 1 cycle, then goes to RUN.
  - A `door_closed` drop in FIRE is detected on the next RUN cycle.
- **RUN**
  - Outputs: `door_lock`=1, `busy`=1.
  - Goes to UNLOCK on `spin`=1.
  - Otherwise goes to FAULT on `door_closed`=0, or when `cnt`==`RUN_TIMEOUT-1` with no `spin`.
  - If `spin` and the door drop coincide, `spin` wins: the door is locked, so the drop is a sensor glitch.
- **UNLOCK**
  - Outputs: `door_lock`=1, `busy`=1.
  - Goes to IDLE when `cnt`==`UNLOCK_CYCLES-1`.
  - `door_closed` is ignored, because the drum is spinning down.
- **FAULT**
  - Outputs: `fault`=1, `door_lock`=0, `busy`=0.
  - Goes to IDLE when `door_closed`=1 and `btn_s`=0 in the same cycle.
- **Output decoding:** all outputs are Moore, decoded from registered state, so they are glitch-free.

## Timing
- Button to rise event: 2–3 cycles after `start_btn` rises, depending on synchroniser phase.
- Rise event to `start`: `DB_CYCLES + LOCK_CYCLES + 1` cycles. This is 8 with defaults: the rise is seen in an IDLE cycle, and `start` is high in the 8th cycle after it.
- `start` is high for exactly 1 cycle per accepted press.
- The sequencer samples `start` and is in its wash phase in RUN cycle 1, rinse in RUN cycle 2, and spin in RUN cycle 3. RUN therefore lasts 3 cycles nominally.
- `door_lock` covers LOCK + FIRE + RUN + UNLOCK. This is 3+1+3+5 = 12 cycles with defaults.
- `busy` rises 1 cycle after the rise event and falls when IDLE or FAULT is entered.
- After UNLOCK, a new cycle needs a fresh button edge. The earliest next `start` comes 8 cycles after that edge.

## Test plan
- **Nominal cycle:** defaults, door closed, button held 20 cycles, sequencer model attached.
  - `start` is a single pulse, 8 cycles after the rise event.
  - `door_lock` is high for 12 cycles.
  - `busy` then falls.
  - `fault`=0 throughout.
  - There is no second `start` while the button is still held.
- **Bounce:** button high 2 cycles, low 1, high 10.
  - The first DEBOUNCE aborts to IDLE with no lock.
  - The second rise yields `start` 8 cycles later.
- **Door open:**
  - Door opened in LOCK cycle 2: FAULT on the next edge, `door_lock`=0, `fault`=1, and no `start`.
  - Door closed with the button released: IDLE on the next edge and `fault`=0.
- **Sequencer timeout:** `spin` tied to 0. FAULT is entered after exactly 8 RUN cycles, and the lock is released.
- **Priority and glitch:** `spin`=1 and `door_closed`=0 in the same RUN cycle gives UNLOCK, not FAULT. A door drop during UNLOCK is ignored.
- **Reset:** `reset_n` asserted asynchronously mid-RUN.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - The block is in IDLE after release.
  - The held button does not restart the cycle.
